// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//   Sequential shift-and-add unsigned multiplier. One WIDTH-bit ripple-carry
//   adder (a chain of adder_full cells) is reused for WIDTH iterations.
//   Each iteration does the conditional add and the right shift of {A,Q}.
//
// Ports
//   clk      in   1        system clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        multiply request, accepted only while idle
//   a        in   WIDTH    multiplicand, captured when start is accepted
//   b        in   WIDTH    multiplier, captured when start is accepted
//   busy     out  1        operation in progress (CALC or DONE)
//   done     out  1        one-cycle pulse, product valid in this cycle
//   product  out  2*WIDTH  a*b, held until the next accepted start
// -----------------------------------------------------------------------------

// Single-bit full adder cell used to build the ripple-carry chain.
module adder_full (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;     // multiplicand
  logic [WIDTH-1:0]   acc_q, acc_d; // accumulator, product upper half
  logic [WIDTH-1:0]   q_q, q_d;     // multiplier shift register, lower half
  logic               c_q, c_d;     // carry out of the last add
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Shared adder: acc + (Q[0] ? M : 0), carry-in tied low.
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   cy;
  logic             cout;

  assign addend = q_q[0] ? m_q : '0;
  assign cy[0]  = 1'b0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    adder_full u_fa (
      .x  (acc_q[g]),
      .y  (addend[g]),
      .ci (cy[g]),
      .s  (sum[g]),
      .co (cy[g+1])
    );
  end

  assign cout = cy[WIDTH];

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        busy  = 1'b1;
        // Add and shift in one step; cout lands in the accumulator MSB so
        // nothing is lost and the full 2*WIDTH product never overflows.
        acc_d = {cout, sum[WIDTH-1:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        c_d   = cout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // {A,Q} is already registered; after DONE it stays put until the next
  // accepted start clears A.
  assign product = {acc_q, q_q};

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int nvec;
  int nfail;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch the DUT for done pulses over n cycles, sampling on falling edges.
  task automatic watch_done(input int n, output int lat, output int ndone,
                            output logic [2*W-1:0] pcap, output logic bcap,
                            output logic busy_first);
    lat = 0; ndone = 0; pcap = '0; bcap = 1'b0; busy_first = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) busy_first = busy;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat  = i;
          pcap = product;
          bcap = busy;
        end
      end
    end
  endtask

  task automatic do_mult(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input string nm);
    logic [2*W-1:0] exp_p;
    int lat, ndone;
    logic [2*W-1:0] pcap;
    logic bcap, bfirst;
    exp_p = {8'd0, ia} * {8'd0, ib};
    @(negedge clk);
    start = 1'b1; a = ia; b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    watch_done(12, lat, ndone, pcap, bcap, bfirst);
    nvec++;
    if (bfirst !== 1'b1) begin
      nfail++;
      $display("FAIL %s busy_after_start got=%0b want=1", nm, bfirst);
    end
    nvec++;
    if (lat !== 9) begin
      nfail++;
      $display("FAIL %s latency got=%0d want=9", nm, lat);
    end
    nvec++;
    if (ndone !== 1) begin
      nfail++;
      $display("FAIL %s done_count got=%0d want=1", nm, ndone);
    end
    nvec++;
    if (pcap !== exp_p) begin
      nfail++;
      $display("FAIL %s product a=%0d b=%0d got=%h want=%h", nm, ia, ib, pcap, exp_p);
    end
    nvec++;
    if (bcap !== 1'b1) begin
      nfail++;
      $display("FAIL %s busy_at_done got=%0b want=1", nm, bcap);
    end
    nvec++;
    if (busy !== 1'b0 || product !== exp_p) begin
      nfail++;
      $display("FAIL %s idle_hold busy=%0b product=%h want busy=0 product=%h",
               nm, busy, product, exp_p);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      nfail++;
      $display("FAIL reset_state busy=%0b done=%0b product=%h want 0/0/0000",
               busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL post_reset_idle busy=%0b done=%0b want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    do_mult(8'd13, 8'd11, "t1_13x11");
    nvec++;
    if (product !== 16'h008F) begin
      nfail++;
      $display("FAIL t1_const got=%h want=008f", product);
    end
    do_mult(8'hFF, 8'hFF, "t2_ffxff");
    nvec++;
    if (product !== 16'hFE01) begin
      nfail++;
      $display("FAIL t2_const got=%h want=fe01", product);
    end
  endtask

  task automatic test_zero_operands();
    do_mult(8'd0, 8'hA5, "t3_0xa5");
    do_mult(8'hA5, 8'd0, "t3_a5x0");
    do_mult(8'd1, 8'hFF, "edge_1xff");
    do_mult(8'h80, 8'h80, "edge_80x80");
  endtask

  task automatic test_start_while_busy();
    int lat, ndone;
    logic [2*W-1:0] pcap;
    logic bcap, bfirst;
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd5;
    @(posedge clk);
    #1;
    a = 8'd7; b = 8'd7;                 // start stays high through CALC/DONE
    watch_done(9, lat, ndone, pcap, bcap, bfirst);
    nvec++;
    if (lat !== 9 || ndone !== 1) begin
      nfail++;
      $display("FAIL t4_single_done lat=%0d count=%0d want lat=9 count=1", lat, ndone);
    end
    nvec++;
    if (pcap !== 16'd15) begin
      nfail++;
      $display("FAIL t4_product got=%h want=000f", pcap);
    end
    @(negedge clk);                     // IDLE cycle after DONE
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL t4_idle_gap busy=%0b done=%0b want 0/0", busy, done);
    end
    @(posedge clk);                     // held start is accepted here
    #1;
    start = 1'b0;
    watch_done(9, lat, ndone, pcap, bcap, bfirst);
    nvec++;
    if (lat !== 9 || ndone !== 1 || pcap !== 16'd49) begin
      nfail++;
      $display("FAIL t4_second lat=%0d count=%0d product=%h want 9/1/0031",
               lat, ndone, pcap);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, ndone;
    logic [2*W-1:0] pcap;
    logic bcap, bfirst;
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);          // now in CALC with cnt=4
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      nfail++;
      $display("FAIL t5_async_clear busy=%0b done=%0b product=%h want 0/0/0000",
               busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    watch_done(15, lat, ndone, pcap, bcap, bfirst);
    nvec++;
    if (ndone !== 0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL t5_no_done count=%0d busy=%0b want 0/0", ndone, busy);
    end
    do_mult(8'd200, 8'd100, "t5_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_mult(ra, rb, "t6_random");
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    test_reset();
    test_basic();
    test_zero_operands();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
